// File: rtl/acs_scheduler.sv
// rtl/acs_scheduler.sv - time-multiplexed ACS sequencer for the Viterbi decoder
// Walks all trellis states per symbol, double-buffers path metrics and normalizes them.
module acs_scheduler #(
   parameter int WD_DIST     = 2,
   parameter int WD_METR     = 8,
   parameter int SBITS       = 2,
   parameter int INIT_METR   = 64,
   parameter int NORM_THRESH = 128
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               sym_valid,
   output logic               sym_ready,
   output logic [SBITS-1:0]   bm_state,
   input  logic [WD_DIST-1:0] dist0_in,
   input  logic [WD_DIST-1:0] dist1_in,
   output logic               acs_cmp_en,
   output logic [WD_DIST-1:0] acs_d0,
   output logic [WD_DIST-1:0] acs_d1,
   output logic [WD_METR-1:0] acs_pm0,
   output logic [WD_METR-1:0] acs_pm1,
   input  logic               acs_survivor,
   input  logic [WD_METR-1:0] acs_metric,
   output logic               surv_valid,
   output logic [SBITS-1:0]   surv_state,
   output logic               surv_bit,
   output logic               sym_done
);

   localparam int N  = 1 << SBITS;
   localparam int WW = $clog2(SBITS + 1);

   typedef enum logic [1:0] {IDLE, RUN, SWAP} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [SBITS-1:0]   s;
   logic [SBITS:0]     s_dbl;
   logic [SBITS-1:0]   p0;
   logic [SBITS-1:0]   p1;
   logic [WD_METR-1:0] cur [N];
   logic [WD_METR-1:0] nxt [N];
   logic [WD_METR-1:0] min_metr;
   logic [WW-1:0]      warm;
   logic               do_norm;

   // Shuffle-exchange trellis: predecessors of s are 2s and 2s+1 modulo N.
   assign s_dbl   = {s, 1'b0};
   assign p0      = s_dbl[SBITS-1:0];
   assign p1      = p0 | SBITS'(1);
   assign do_norm = (min_metr >= WD_METR'(NORM_THRESH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      sym_ready  = 1'b0;
      surv_valid = 1'b0;
      sym_done   = 1'b0;
      acs_cmp_en = 1'b0;
      case (state)
         IDLE: begin
            sym_ready = 1'b1;
            if (sym_valid && !clr) state_nxt = RUN;
         end
         RUN: begin
            surv_valid = 1'b1;
            acs_cmp_en = (warm == WW'(SBITS));
            if (s == SBITS'(N - 1)) state_nxt = SWAP;
         end
         SWAP: begin
            sym_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (clr) state_nxt = IDLE;
   end

   always_comb begin
      bm_state   = s;
      surv_state = s;
      surv_bit   = acs_survivor;
      acs_d0     = dist0_in;
      acs_d1     = dist1_in;
      acs_pm0    = cur[p0];
      acs_pm1    = cur[p1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     s <= '0;
      else if (clr || state != RUN)   s <= '0;
      else                            s <= s + SBITS'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) cur[i] <= (i == 0) ? '0 : WD_METR'(INIT_METR);
         warm     <= '0;
         min_metr <= '1;
      end else if (clr) begin
         for (int i = 0; i < N; i++) cur[i] <= (i == 0) ? '0 : WD_METR'(INIT_METR);
         warm     <= '0;
         min_metr <= '1;
      end else if (state == RUN) begin
         if (acs_metric < min_metr) min_metr <= acs_metric;
      end else if (state == SWAP) begin
         // Subtract only when every metric clears the threshold, so no underflow.
         for (int i = 0; i < N; i++)
            cur[i] <= do_norm ? nxt[i] - WD_METR'(NORM_THRESH) : nxt[i];
         if (warm != WW'(SBITS)) warm <= warm + WW'(1);
         min_metr <= '1;
      end
   end

   always_ff @(posedge clk) begin
      if (state == RUN && !clr) nxt[s] <= acs_metric;
   end

endmodule
